// File: rtl/sha2_pkg.sv
// Shared constants and types for the SHA-2 message-schedule unit.
package sha2_pkg;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  // sigma0 / sigma1 rotate and shift amounts, SHA-256 then SHA-512
  localparam int S0_R1_32 = 7;
  localparam int S0_R2_32 = 18;
  localparam int S0_S_32  = 3;
  localparam int S1_R1_32 = 17;
  localparam int S1_R2_32 = 19;
  localparam int S1_S_32  = 10;

  localparam int S0_R1_64 = 1;
  localparam int S0_R2_64 = 8;
  localparam int S0_S_64  = 7;
  localparam int S1_R1_64 = 19;
  localparam int S1_R2_64 = 61;
  localparam int S1_S_64  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_t;

endpackage

// File: rtl/sha2_small_sigma.sv
// Combinational SHA-2 small sigma: ROTR^ROTR^SHR in 32-bit or 64-bit mode.
// In 32-bit mode the rotation is confined to bits [31:0] and the result is
// zero-extended.
module sha2_small_sigma #(
  parameter int R1_32 = 7,
  parameter int R2_32 = 18,
  parameter int S_32  = 3,
  parameter int R1_64 = 1,
  parameter int R2_64 = 8,
  parameter int S_64  = 7
) (
  input  logic        i_mode,
  input  logic [63:0] i_x,
  output logic [63:0] o_y
);

  logic [31:0] w_x32;
  logic [31:0] w_y32;
  logic [63:0] w_y64;

  assign w_x32 = i_x[31:0];

  assign w_y32 = ((w_x32 >> R1_32) | (w_x32 << (32 - R1_32))) ^
                 ((w_x32 >> R2_32) | (w_x32 << (32 - R2_32))) ^
                 (w_x32 >> S_32);

  assign w_y64 = ((i_x >> R1_64) | (i_x << (64 - R1_64))) ^
                 ((i_x >> R2_64) | (i_x << (64 - R2_64))) ^
                 (i_x >> S_64);

  assign o_y = i_mode ? w_y64 : {32'h0, w_y32};

endmodule

// File: rtl/sha2_msg_schedule.sv
// Streaming SHA-256 / SHA-512 message schedule: takes 16 message words and
// emits W_0..W_{R-1} through a single registered output slot.
//
//   state  | meaning
//   IDLE   | waiting for word 0; accepting it latches the block mode
//   LOAD   | accepting words 1..15, passing each straight to the output
//   EXPAND | computing W_16..W_{R-1} from the 16-word sliding buffer
module sha2_msg_schedule
  import sha2_pkg::*;
#(
  parameter int SUPPORT_512 = 1,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [6:0]            out_index,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [6:0] LAST_256 = 7'(ROUNDS_256 - 1);
  localparam logic [6:0] LAST_512 = 7'(ROUNDS_512 - 1);

  state_t      r_state;
  logic [6:0]  r_t;
  logic        r_m;
  logic [63:0] r_buf [16];
  logic [63:0] r_out_data;
  logic [6:0]  r_out_index;
  logic        r_out_last;
  logic        r_out_valid;

  logic        w_slot_free;
  logic        w_mode_in;
  logic        w_m_cur;
  logic [63:0] w_in_masked;
  logic        w_accept;
  logic        w_step;
  logic [3:0]  w_i0;
  logic [3:0]  w_i1;
  logic [3:0]  w_i9;
  logic [3:0]  w_i14;
  logic [63:0] w_s0;
  logic [63:0] w_s1;
  logic [63:0] w_sum;
  logic [63:0] w_w;
  logic [6:0]  w_last_t;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_mode_in   = (SUPPORT_512 != 0) && mode;
  // Word 0 is masked with the mode being latched in the same cycle
  assign w_m_cur     = (r_state == IDLE) ? w_mode_in : r_m;
  assign w_in_masked = w_m_cur ? 64'(in_data) : {32'h0, in_data[31:0]};

  assign in_ready = !rst && w_slot_free && (r_state != EXPAND);
  assign w_accept = in_valid && in_ready;
  assign w_step   = !rst && (r_state == EXPAND) && w_slot_free;

  assign w_i0  = r_t[3:0];
  assign w_i1  = r_t[3:0] + 4'd1;
  assign w_i9  = r_t[3:0] + 4'd9;
  assign w_i14 = r_t[3:0] + 4'd14;

  sha2_small_sigma #(
    .R1_32(S0_R1_32), .R2_32(S0_R2_32), .S_32(S0_S_32),
    .R1_64(S0_R1_64), .R2_64(S0_R2_64), .S_64(S0_S_64)
  ) u_sigma0 (
    .i_mode (r_m),
    .i_x    (r_buf[w_i1]),
    .o_y    (w_s0)
  );

  sha2_small_sigma #(
    .R1_32(S1_R1_32), .R2_32(S1_R2_32), .S_32(S1_S_32),
    .R1_64(S1_R1_64), .R2_64(S1_R2_64), .S_64(S1_S_64)
  ) u_sigma1 (
    .i_mode (r_m),
    .i_x    (r_buf[w_i14]),
    .o_y    (w_s1)
  );

  assign w_sum    = w_s1 + r_buf[w_i9] + w_s0 + r_buf[w_i0];
  assign w_w      = r_m ? w_sum : {32'h0, w_sum[31:0]};
  assign w_last_t = r_m ? LAST_512 : LAST_256;

  // Sliding word buffer; W_t overwrites W_{t-16}, which is read the same cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[w_i0] <= w_in_masked;
    end else if (w_step) begin
      r_buf[w_i0] <= w_w;
    end
  end

  // Sequencer and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_t         <= 7'd0;
      r_m         <= 1'b0;
      r_out_data  <= 64'h0;
      r_out_index <= 7'd0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_slot_free) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      case (r_state)
        IDLE, LOAD: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_in_masked;
            r_out_index <= r_t;
            r_t         <= r_t + 7'd1;
            if (r_state == IDLE) begin
              r_m <= w_mode_in;
            end
            r_state <= (r_t == 7'd15) ? EXPAND : LOAD;
          end
        end
        EXPAND: begin
          if (w_step) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_w;
            r_out_index <= r_t;
            if (r_t == w_last_t) begin
              r_out_last <= 1'b1;
              r_t        <= 7'd0;
              r_state    <= IDLE;
            end else begin
              r_t <= r_t + 7'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Bench for sha2_msg_schedule: "abc" blocks in both modes, upper-half junk
// in 32-bit mode, random backpressure, back-to-back blocks, mid-block reset.
module tb_sha2_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [6:0]  out_index;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  sha2_msg_schedule #(.SUPPORT_512(1), .DATA_WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] got_d [160];
  logic [6:0]  got_i [160];
  logic        got_l [160];
  int          n_got, gaps, viol;
  logic        stop_hit;

  logic [63:0] exp_d [160];
  logic [6:0]  exp_i [160];
  logic        exp_l [160];
  int          n_exp;
  logic [63:0] rw [80];

  typedef struct {
    logic        m;
    logic        hi;
    logic        rnd;
    int          idx;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] msg_word(input int t, input logic m);
    if (t == 0)  return m ? 64'h6162638000000000 : 64'h0000000061626380;
    if (t == 15) return 64'h18;
    return 64'h0;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [31:0] x32;
    logic [31:0] r32;
    if (w == 32) begin
      x32 = x[31:0];
      r32 = (x32 >> n) | (x32 << (32 - n));
      return {32'h0, r32};
    end
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input logic m);
    if (m) return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ ({32'h0, x[31:0]} >> 3);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input logic m);
    if (m) return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ ({32'h0, x[31:0]} >> 10);
  endfunction

  // Appends the reference schedule of one "abc" block to the expected stream
  task automatic build_block(input logic m);
    int r;
    logic [63:0] s;
    r = m ? 80 : 64;
    for (int t = 0; t < r; t++) begin
      if (t < 16) begin
        rw[t] = msg_word(t, m);
      end else begin
        s = sig1(rw[t-2], m) + rw[t-7] + sig0(rw[t-15], m) + rw[t-16];
        rw[t] = m ? s : {32'h0, s[31:0]};
      end
      exp_d[n_exp] = rw[t];
      exp_i[n_exp] = 7'(t);
      exp_l[n_exp] = (t == r - 1);
      n_exp++;
    end
  endtask

  // Feeds nblk blocks (modes m0, m1) and collects the output stream.
  // Mode is inverted on every word except word 0 to prove it is ignored.
  task automatic run_seq(input logic m0, input logic m1, input int nblk,
                         input logic hi, input logic rnd, input int stop_idx);
    int wi, want, cyc, wd;
    logic bm, prev_stall, pl;
    logic [63:0] w, pd;
    logic [6:0] pi;
    want = (m0 ? 80 : 64) + ((nblk > 1) ? (m1 ? 80 : 64) : 0);
    n_got = 0; gaps = 0; viol = 0; cyc = 0; wi = 0;
    prev_stall = 1'b0; pd = 64'h0; pi = 7'd0; pl = 1'b0;
    stop_hit = 1'b0;
    while (n_got < want && cyc < 3000) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wi < nblk * 16) begin
        bm = (wi / 16 == 0) ? m0 : m1;
        wd = wi % 16;
        w  = msg_word(wd, bm);
        if (hi) w[63:32] = 32'hFFFFFFFF;
        in_valid = 1'b1;
        in_data  = w;
        mode     = (wd == 0) ? bm : ~bm;
      end else begin
        in_valid = 1'b0;
        in_data  = 64'h0;
        mode     = ~m0;
      end
      #1;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== pd ||
                         out_index !== pi || out_last !== pl)) viol++;
      if (stop_idx >= 0 && out_valid && out_index == 7'(stop_idx)) begin
        stop_hit = 1'b1;
        return;
      end
      if (in_valid && in_ready) wi++;
      if (n_got > 0 && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        got_d[n_got] = out_data;
        got_i[n_got] = out_index;
        got_l[n_got] = out_last;
        n_got++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pi = out_index; pl = out_last;
      cyc++;
    end
    if (stop_idx < 0) chk("words received", 64'(n_got), 64'(want));
  endtask

  task automatic check_stream(input string tag);
    int de, ie, le, first;
    de = 0; ie = 0; le = 0; first = -1;
    for (int k = 0; k < n_exp; k++) begin
      if (k >= n_got) break;
      if (got_d[k] !== exp_d[k]) begin
        de++;
        if (first < 0) first = k;
      end
      if (got_i[k] !== exp_i[k]) ie++;
      if (got_l[k] !== exp_l[k]) le++;
    end
    chk({tag, " data errors"}, 64'(de), 64'd0);
    chk({tag, " index errors"}, 64'(ie), 64'd0);
    chk({tag, " last errors"}, 64'(le), 64'd0);
    if (first >= 0)
      $display("  %s first bad word %0d: got=%h expected=%h", tag, first, got_d[first], exp_d[first]);
  endtask

  initial begin
    vt[0] = '{m: 1'b0, hi: 1'b0, rnd: 1'b0, idx: 16, exp: 64'h0000000061626380};
    vt[1] = '{m: 1'b0, hi: 1'b0, rnd: 1'b0, idx: 17, exp: 64'h00000000000F0000};
    vt[2] = '{m: 1'b1, hi: 1'b0, rnd: 1'b0, idx: 16, exp: 64'h6162638000000000};
    vt[3] = '{m: 1'b1, hi: 1'b0, rnd: 1'b0, idx: 17, exp: 64'h00030000000000C0};
    vt[4] = '{m: 1'b0, hi: 1'b1, rnd: 1'b0, idx: 16, exp: 64'h0000000061626380};
    vt[5] = '{m: 1'b0, hi: 1'b1, rnd: 1'b0, idx: 17, exp: 64'h00000000000F0000};
    vt[6] = '{m: 1'b0, hi: 1'b0, rnd: 1'b1, idx: 17, exp: 64'h00000000000F0000};
    vt[7] = '{m: 1'b1, hi: 1'b0, rnd: 1'b1, idx: 17, exp: 64'h00030000000000C0};

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data",  out_data,       64'd0);
    chk("reset out_index", 64'(out_index), 64'd0);
    chk("reset out_last",  64'(out_last),  64'd0);
    chk("reset busy",      64'(busy),      64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      n_exp = 0;
      build_block(vt[v].m);
      run_seq(vt[v].m, 1'b0, 1, vt[v].hi, vt[v].rnd, -1);
      chk($sformatf("vec%0d W%0d", v, vt[v].idx), got_d[vt[v].idx], vt[v].exp);
      check_stream($sformatf("vec%0d", v));
      if (vt[v].rnd) chk($sformatf("vec%0d stall stability", v), 64'(viol), 64'd0);
    end

    // Back-to-back SHA-256 then SHA-512 with no idle cycles
    n_exp = 0;
    build_block(1'b0);
    build_block(1'b1);
    run_seq(1'b0, 1'b1, 2, 1'b0, 1'b0, -1);
    check_stream("b2b");
    chk("b2b output gaps", 64'(gaps), 64'd0);
    chk("b2b blk1 W17", got_d[64 + 17], 64'h00030000000000C0);
    chk("b2b blk1 last", 64'(got_l[143]), 64'd1);

    // Reset while EXPAND is computing W30
    run_seq(1'b0, 1'b0, 1, 1'b0, 1'b0, 29);
    chk("reached t=30", 64'(stop_hit), 64'd1);
    chk("pre-reset busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid-reset out_valid", 64'(out_valid), 64'd0);
    chk("mid-reset busy",      64'(busy),      64'd0);
    chk("mid-reset in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post-reset busy",      64'(busy),      64'd0);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    n_exp = 0;
    build_block(1'b0);
    run_seq(1'b0, 1'b0, 1, 1'b0, 1'b0, -1);
    chk("post-reset W16", got_d[16], 64'h0000000061626380);
    chk("post-reset W17", got_d[17], 64'h00000000000F0000);
    check_stream("post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
